gfx_line_draw: RTL and testbench
================================

Name: gfx_line_draw

Overview:
Bresenham line rasteriser that sits directly upstream of the striped-SRAM VGA framebuffer. It accepts one line command (endpoints plus colour) and emits a stream of framebuffer pixel writes (gfx_x, gfx_y, gfx_color) on a valid/ready handshake. Timing is 1 pixel/cycle while the sink is ready. It runs on clk (the 100 MHz AXI/system clock), the same domain as the framebuffer's gfx write port.

Parameters:
FB_X_BITS, 10, width of x coordinates (framebuffer columns).
FB_Y_BITS, 9, width of y coordinates (framebuffer rows).
PIXEL_BITS, 12, colour width, passed through unchanged.

Ports:
clk  input  1  system clock; all logic on posedge clk.
reset  input  1  synchronous, active-high.
cmd_valid  input  1  line command present.
cmd_ready  output  1  block can accept a command; high only in IDLE.
cmd_x0  input  FB_X_BITS  start x.
cmd_y0  input  FB_Y_BITS  start y.
cmd_x1  input  FB_X_BITS  end x.
cmd_y1  input  FB_Y_BITS  end y.
cmd_color  input  PIXEL_BITS  line colour.
gfx_x  output  FB_X_BITS  pixel x.
gfx_y  output  FB_Y_BITS  pixel y.
gfx_color  output  PIXEL_BITS  pixel colour.
gfx_valid  output  1  pixel present.
gfx_ready  input  1  sink accepts pixel.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, gfx_valid=0, gfx_x=0, gfx_y=0, gfx_color=0, done=0, busy=0. cmd_ready=1 in the first cycle after reset deasserts.
- Reset mid-line: the line is abandoned. gfx_valid=0 the cycle after reset is sampled, and no further pixels from that line are emitted.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the endpoints and colour, then go to SETUP.
- State SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy; cur = (x0, y0).
  - Go to DRAW.
- State DRAW:
  - gfx_valid=1; gfx_x/gfx_y = cur; gfx_color = latched colour.
  - On gfx_valid&&gfx_ready with cur == (x1, y1): go to IDLE. done=1 and cmd_ready=1 in the next cycle.
  - Otherwise, on handshake, compute e2 = 2*err:
    - if e2 >= dy: err += dy, x += sx.
    - if e2 <= dx: err += dx, y += sy.
    - Both updates apply in the same cycle when both hold; err takes the sum of both increments.
- Latency: command accepted at cycle N → SETUP at N+1 → first gfx_valid at N+2.
- Pixel count: exactly max(dx, -dy)+1, in endpoint order x0,y0 → x1,y1.
- Handshake rules (AXI-stream):
  - While gfx_valid && !gfx_ready, gfx_x/y/color hold stable and gfx_valid stays high.
  - gfx_valid never drops without a handshake, except on reset.
- Arithmetic:
  - W = max(FB_X_BITS, FB_Y_BITS).
  - dx, dy and err are signed, W+2 bits; e2 is signed, W+3 bits. No overflow for any endpoints.
  - Coordinates wrap-free because endpoints are in range.
- Boundary cases:
  - x0==x1 && y0==y1: exactly one pixel, then done.
  - Vertical and horizontal lines use the same path.
- Back-to-back: cmd_valid held high is accepted in the cycle done is high. The next line's first pixel appears 2 cycles later.
- busy=1 in SETUP and DRAW. cmd_ready=0 outside IDLE; commands presented then are not consumed.

Test Plan:
1. Horizontal line: (0,0)->(7,0), colour 0xF00, gfx_ready=1 → 8 consecutive pixels x=0..7, y=0, colour 0xF00. First gfx_valid 2 cycles after command accept; done one cycle after pixel x=7.
2. Steep reverse line: (5,7)->(2,0) → pixels (5,7),(5,6),(4,5),(4,4),(3,3),(3,2),(2,1),(2,0), then done.
3. Backpressure: same line as test 1 with gfx_ready alternating 1,0,1,0 → identical 8-pixel sequence. Outputs hold stable during every ready-low cycle; cmd_ready=0 until done; done after 8 handshakes.
4. Degenerate point: (3,3)->(3,3), colour 0x0A5 → exactly one pixel (3,3, 0x0A5), then done. No second gfx_valid.
5. Reset mid-line: (0,0)->(127,0); assert reset for 1 cycle after 3 handshakes → gfx_valid=0 next cycle, busy=0, cmd_ready=1. A new command (1,1)->(2,2) then emits (1,1),(2,2) only.
6. Back-to-back: hold cmd_valid high with (0,0)->(1,1), then (4,0)->(4,2) → (0,0),(1,1), done, then (4,0),(4,1),(4,2), done. Second command accepted in the done cycle.

Source files
------------

// File: rtl/gfx_line_draw.sv
`default_nettype none
// ============================================================================
// Module  : gfx_line_draw
// Brief   : Bresenham line rasteriser; one command in, a stream of framebuffer
//           pixel writes out on a valid/ready handshake (1 pixel/cycle).
// Rev     : 1.0
// ============================================================================
module gfx_line_draw #(
  parameter int FB_X_BITS  = 10,
  parameter int FB_Y_BITS  = 9,
  parameter int PIXEL_BITS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FB_X_BITS-1:0]  cmd_x0,
  input  logic [FB_Y_BITS-1:0]  cmd_y0,
  input  logic [FB_X_BITS-1:0]  cmd_x1,
  input  logic [FB_Y_BITS-1:0]  cmd_y1,
  input  logic [PIXEL_BITS-1:0] cmd_color,
  output logic [FB_X_BITS-1:0]  gfx_x,
  output logic [FB_Y_BITS-1:0]  gfx_y,
  output logic [PIXEL_BITS-1:0] gfx_color,
  output logic                  gfx_valid,
  input  logic                  gfx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int c_w  = (FB_X_BITS > FB_Y_BITS) ? FB_X_BITS : FB_Y_BITS;
  localparam int c_dw = c_w + 2;
  localparam logic [FB_X_BITS-1:0] c_x_one = FB_X_BITS'(1);
  localparam logic [FB_Y_BITS-1:0] c_y_one = FB_Y_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [FB_X_BITS-1:0]    r_x0, r_x1;
  logic [FB_Y_BITS-1:0]    r_y0, r_y1;
  logic [PIXEL_BITS-1:0]   r_color;
  logic signed [c_dw-1:0]  r_dx, r_dy, r_err;
  logic                    r_sx_neg, r_sy_neg;

  logic signed [c_dw-1:0]  w_x0_s, w_x1_s, w_y0_s, w_y1_s;
  logic signed [c_dw-1:0]  w_dx_raw, w_dy_raw, w_dx_abs, w_dy_negabs;
  logic signed [c_dw:0]    w_e2, w_dx_ext, w_dy_ext;
  logic signed [c_dw-1:0]  w_err_next;
  logic                    w_step_x, w_step_y, w_at_end, w_hs;

  // Coordinates are unsigned; zero-extend into the signed difference domain.
  assign w_x0_s = $signed({{(c_dw-FB_X_BITS){1'b0}}, r_x0});
  assign w_x1_s = $signed({{(c_dw-FB_X_BITS){1'b0}}, r_x1});
  assign w_y0_s = $signed({{(c_dw-FB_Y_BITS){1'b0}}, r_y0});
  assign w_y1_s = $signed({{(c_dw-FB_Y_BITS){1'b0}}, r_y1});

  assign w_dx_raw    = w_x1_s - w_x0_s;
  assign w_dy_raw    = w_y1_s - w_y0_s;
  assign w_dx_abs    = w_dx_raw[c_dw-1] ? -w_dx_raw : w_dx_raw;
  assign w_dy_negabs = w_dy_raw[c_dw-1] ? w_dy_raw : -w_dy_raw;

  assign w_e2     = $signed({r_err, 1'b0});
  assign w_dx_ext = $signed({r_dx[c_dw-1], r_dx});
  assign w_dy_ext = $signed({r_dy[c_dw-1], r_dy});
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);
  assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

  assign w_at_end = (gfx_x == r_x1) && (gfx_y == r_y1);
  assign w_hs     = gfx_valid && gfx_ready;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_x1      <= '0;
      r_y0      <= '0;
      r_y1      <= '0;
      r_color   <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_err     <= '0;
      r_sx_neg  <= 1'b0;
      r_sy_neg  <= 1'b0;
      gfx_x     <= '0;
      gfx_y     <= '0;
      gfx_color <= '0;
      gfx_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x0    <= cmd_x0;
            r_y0    <= cmd_y0;
            r_x1    <= cmd_x1;
            r_y1    <= cmd_y1;
            r_color <= cmd_color;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_dx      <= w_dx_abs;
          r_dy      <= w_dy_negabs;
          r_err     <= w_dx_abs + w_dy_negabs;
          r_sx_neg  <= !(r_x0 < r_x1);
          r_sy_neg  <= !(r_y0 < r_y1);
          gfx_x     <= r_x0;
          gfx_y     <= r_y0;
          gfx_color <= r_color;
          gfx_valid <= 1'b1;
          r_state   <= S_DRAW;
        end
        S_DRAW: begin
          if (w_hs) begin
            if (w_at_end) begin
              gfx_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              // Both axis steps may fire together; err absorbs both increments.
              r_err <= w_err_next;
              if (w_step_x)
                gfx_x <= r_sx_neg ? gfx_x - c_x_one : gfx_x + c_x_one;
              if (w_step_y)
                gfx_y <= r_sy_neg ? gfx_y - c_y_one : gfx_y + c_y_one;
            end
          end
        end
        default: begin
          gfx_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfx_line_draw.sv
`default_nettype none
// ============================================================================
// Module  : tb_gfx_line_draw
// Brief   : Self-checking bench for gfx_line_draw against a pixel-list model.
// Rev     : 1.0
// ============================================================================
module tb_gfx_line_draw;

  localparam int XB = 10;
  localparam int YB = 9;
  localparam int PB = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XB-1:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [YB-1:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [PB-1:0] cmd_color = '0;
  logic [XB-1:0] gfx_x;
  logic [YB-1:0] gfx_y;
  logic [PB-1:0] gfx_color;
  logic          gfx_valid;
  logic          gfx_ready = 1'b1;
  logic          busy;
  logic          done;

  gfx_line_draw #(.FB_X_BITS(XB), .FB_Y_BITS(YB), .PIXEL_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .gfx_x(gfx_x), .gfx_y(gfx_y), .gfx_color(gfx_color),
    .gfx_valid(gfx_valid), .gfx_ready(gfx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t q[$];
  pix_t tmp_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, first_valid_cyc = 0, hs_cnt = 0, acc_cnt = 0;
  int ready_mode = 0;
  bit done_exp = 0, prev_stall = 0, chk_acc_done = 0;
  int px = 0, py = 0, pc = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel list for one line, straight from the Bresenham rules.
  function automatic void gen_line(int x0, int y0, int x1, int y1, int c);
    int dx, dy, sx, sy, err, e2, x, y;
    pix_t p;
    tmp_q.delete();
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int n = 0; n < 4096; n++) begin
      p.x = x; p.y = y; p.c = c;
      tmp_q.push_back(p);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      done_exp = 0;
      prev_stall = 0;
    end else begin
      check("cmd_ready", int'(cmd_ready), int'(q.size() == 0));
      check("busy", int'(busy), int'(q.size() != 0));
      check("done", int'(done), int'(done_exp));
      check("gfx_valid", int'(gfx_valid), int'(q.size() > 0 && cyc >= first_valid_cyc));
      if (gfx_valid && q.size() > 0) begin
        check("gfx_x", int'(gfx_x), q[0].x);
        check("gfx_y", int'(gfx_y), q[0].y);
        check("gfx_color", int'(gfx_color), q[0].c);
      end
      if (prev_stall) begin
        check("hold_valid", int'(gfx_valid), 1);
        check("hold_x", int'(gfx_x), px);
        check("hold_y", int'(gfx_y), py);
        check("hold_color", int'(gfx_color), pc);
      end
      prev_stall = gfx_valid && !gfx_ready;
      px = int'(gfx_x); py = int'(gfx_y); pc = int'(gfx_color);
      done_exp = 0;
      if (gfx_valid && gfx_ready && q.size() > 0) begin
        void'(q.pop_front());
        hs_cnt++;
        if (q.size() == 0) done_exp = 1;
      end
      if (cmd_valid && cmd_ready) begin
        if (chk_acc_done) check("b2b_accept_in_done", int'(done), 1);
        gen_line(int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1), int'(cmd_color));
        foreach (tmp_q[i]) q.push_back(tmp_q[i]);
        first_valid_cyc = cyc + 2;
        acc_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: gfx_ready = 1'b1;
        1: gfx_ready = !gfx_ready;
        default: gfx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic wait_acc(input int a0);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_cnt != a0) begin ok = 1; break; end
    end
    #1;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    int a0;
    a0 = acc_cnt;
    cmd_x0 = XB'(x0); cmd_y0 = YB'(y0); cmd_x1 = XB'(x1); cmd_y1 = YB'(y1);
    cmd_color = PB'(c);
    cmd_valid = 1'b1;
    wait_acc(a0);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int h0, a0, ok;
    int t2x[8];
    int t2y[8];
    t2x = '{5, 5, 4, 4, 3, 3, 2, 2};
    t2y = '{7, 6, 5, 4, 3, 2, 1, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_gfx_valid", int'(gfx_valid), 0);
    check("rst_gfx_x", int'(gfx_x), 0);
    check("rst_gfx_y", int'(gfx_y), 0);
    check("rst_gfx_color", int'(gfx_color), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);

    // Pin the model with hand-derived pixel lists.
    gen_line(5, 7, 2, 0, 0);
    check("model_t2_len", tmp_q.size(), 8);
    for (int i = 0; i < 8 && i < tmp_q.size(); i++) begin
      check("model_t2_x", tmp_q[i].x, t2x[i]);
      check("model_t2_y", tmp_q[i].y, t2y[i]);
    end
    gen_line(0, 0, 7, 0, 'hF00);
    check("model_t1_len", tmp_q.size(), 8);
    check("model_t1_last_x", tmp_q[tmp_q.size()-1].x, 7);
    gen_line(3, 3, 3, 3, 'h0A5);
    check("model_t4_len", tmp_q.size(), 1);

    // Horizontal line, no backpressure.
    ready_mode = 0;
    h0 = hs_cnt;
    send_cmd(0, 0, 7, 0, 'hF00);
    wait_idle();
    check("t1_pixels", hs_cnt - h0, 8);

    // Steep reverse line.
    h0 = hs_cnt;
    send_cmd(5, 7, 2, 0, 'h123);
    wait_idle();
    check("t2_pixels", hs_cnt - h0, 8);

    // Alternating backpressure.
    ready_mode = 1;
    h0 = hs_cnt;
    send_cmd(0, 0, 7, 0, 'hF00);
    wait_idle();
    check("t3_pixels", hs_cnt - h0, 8);

    // Degenerate point.
    ready_mode = 0;
    h0 = hs_cnt;
    send_cmd(3, 3, 3, 3, 'h0A5);
    wait_idle();
    check("t4_pixels", hs_cnt - h0, 1);

    // Reset in the middle of a long line.
    h0 = hs_cnt;
    send_cmd(0, 0, 127, 0, 'h00F);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (hs_cnt - h0 >= 3) begin ok = 1; break; end
    end
    if (!ok) check("t5_hs_timeout", 0, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t5_valid_after_reset", int'(gfx_valid), 0);
    check("t5_busy_after_reset", int'(busy), 0);
    check("t5_ready_after_reset", int'(cmd_ready), 1);
    h0 = hs_cnt;
    send_cmd(1, 1, 2, 2, 'h777);
    wait_idle();
    check("t5_new_line_pixels", hs_cnt - h0, 2);

    // Back-to-back commands with cmd_valid held high.
    h0 = hs_cnt;
    a0 = acc_cnt;
    cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 1; cmd_y1 = 1; cmd_color = 'h111;
    cmd_valid = 1'b1;
    wait_acc(a0);
    cmd_x0 = 4; cmd_y0 = 0; cmd_x1 = 4; cmd_y1 = 2; cmd_color = 'h222;
    chk_acc_done = 1;
    a0 = acc_cnt;
    wait_acc(a0);
    cmd_valid = 1'b0;
    chk_acc_done = 0;
    wait_idle();
    check("t6_pixels", hs_cnt - h0, 5);

    // Randomised lines and backpressure.
    for (int n = 0; n < 24; n++) begin
      int lim_x, lim_y;
      ready_mode = $urandom_range(0, 2);
      lim_x = (n % 8 == 7) ? 1023 : 40;
      lim_y = (n % 8 == 7) ? 511 : 40;
      send_cmd($urandom_range(0, lim_x), $urandom_range(0, lim_y),
               $urandom_range(0, lim_x), $urandom_range(0, lim_y),
               $urandom_range(0, 4095));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
